// File: rtl/eth_frame_reader_pkg.sv
// Shared widths, limits and FSM encoding for the Ethernet frame reader.
package eth_pkg;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 8;
    localparam int LEN_W   = ADDR_W + 1;
    localparam int MAX_LEN = 1024;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_e;
endpackage

// File: rtl/eth_frame_reader_if.sv
// Control, frame-buffer read port and TX byte stream of the frame reader.
interface eth_frame_reader_if import eth_pkg::*; ();
    logic              Start;
    logic [ADDR_W-1:0] StartAddr;
    logic [LEN_W-1:0]  Length;
    logic              Abort;
    logic              Busy;
    logic              Done;
    logic [ADDR_W-1:0] RdAddress;
    logic              RdClockEn;
    logic [DATA_W-1:0] Q;
    logic [DATA_W-1:0] TxData;
    logic              TxValid;
    logic              TxLast;
    logic              TxReady;

    modport master (
        input  Start, StartAddr, Length, Abort, Q, TxReady,
        output Busy, Done, RdAddress, RdClockEn, TxData, TxValid, TxLast
    );

    modport slave (
        output Start, StartAddr, Length, Abort, Q, TxReady,
        input  Busy, Done, RdAddress, RdClockEn, TxData, TxValid, TxLast
    );
endinterface

// File: rtl/eth_frame_reader_skid_fifo.sv
// Small power-of-two FIFO that absorbs bytes still in flight from the buffer read port.
module eth_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic [$clog2(DEPTH):0]   occ_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   occ_q;
    logic          do_push, do_pop;

    assign do_pop  = pop_i && (occ_q != '0);
    assign do_push = push_i && ((occ_q != FULL_C) || do_pop);
    assign data_o  = mem_q[rd_q];
    assign occ_o   = occ_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + (AW+1)'(1);
                2'b01:   occ_q <= occ_q - (AW+1)'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end
endmodule

// File: rtl/eth_frame_reader.sv
// Reads a Length-byte frame from the 1024x8 frame buffer (1-cycle read latency)
// and streams it out on a valid/ready byte interface with TxLast and a Done pulse.
module eth_frame_reader import eth_pkg::*; #(
    parameter int BUF_DEPTH = 4
) (
    input logic                RdClock,
    input logic                Reset,
    eth_frame_reader_if.master bus
);
    localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam logic [OCC_W:0] DEPTH_C = (OCC_W+1)'(BUF_DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q;
    logic [LEN_W-1:0]  remain_q, remain_d, len_q, pop_cnt_q;
    logic              inflight_q;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    pending;
    logic [DATA_W-1:0] head;
    logic              issue, start_ok, abort, tx_valid, tx_last, pop;

    // Reads are throttled only by registered occupancy, so TxReady never reaches RdClockEn.
    assign pending  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q};
    assign issue    = (state_q == READ) && (remain_q != '0) && (pending < DEPTH_C);
    assign abort    = bus.Abort && (state_q != IDLE);
    assign start_ok = (state_q == IDLE) && bus.Start && !bus.Abort;
    assign tx_valid = (occ != '0);
    assign tx_last  = tx_valid && (pop_cnt_q == len_q - LEN_W'(1));
    assign pop      = tx_valid && bus.TxReady;

    eth_skid_fifo #(.DEPTH(BUF_DEPTH), .W(DATA_W)) u_skid (
        .clk_i   (RdClock),
        .rst_i   (Reset),
        .flush_i (abort),
        .push_i  (inflight_q),
        .data_i  (bus.Q),
        .pop_i   (pop),
        .data_o  (head),
        .occ_o   (occ)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: if (start_ok) begin
                if (bus.Length == '0) begin
                    state_d = DONE;
                end else begin
                    addr_d   = bus.StartAddr;
                    remain_d = bus.Length;
                    state_d  = READ;
                end
            end
            READ: if (issue) begin
                addr_d   = addr_q + ADDR_W'(1);
                remain_d = remain_q - LEN_W'(1);
                if (remain_q == LEN_W'(1)) state_d = DRAIN;
            end
            DRAIN: if (pop && tx_last) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d  = IDLE;
            remain_d = '0;
        end
    end

    always_ff @(posedge RdClock or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rd_addr_q  <= '0;
            remain_q   <= '0;
            len_q      <= '0;
            pop_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            inflight_q <= issue && !abort;
            if (issue) rd_addr_q <= addr_q;
            if (start_ok) begin
                len_q     <= bus.Length;
                pop_cnt_q <= '0;
            end else if (abort) begin
                pop_cnt_q <= '0;
            end else if (pop) begin
                pop_cnt_q <= pop_cnt_q + LEN_W'(1);
            end
        end
    end

    // The address shows live during an issue and otherwise holds the last one issued.
    assign bus.RdAddress = issue ? addr_q : rd_addr_q;
    assign bus.RdClockEn = issue;
    assign bus.Busy      = (state_q != IDLE);
    assign bus.Done      = (state_q == DONE);
    assign bus.TxValid   = tx_valid;
    assign bus.TxData    = head;
    assign bus.TxLast    = tx_last;
endmodule

// File: tb/tb_eth_frame_reader.sv
// Directed bench for eth_frame_reader with a behavioural 1024x8 buffer behind the read port.
module tb_eth_frame_reader;
    import eth_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    eth_frame_reader_if bus();

    eth_frame_reader #(.BUF_DEPTH(4)) dut (
        .RdClock (clk),
        .Reset   (rst),
        .bus     (bus)
    );

    logic [7:0] mem [MAX_LEN];
    always @(posedge clk) if (bus.RdClockEn === 1'b1) bus.Q <= mem[bus.RdAddress];

    int checks = 0, errors = 0;
    int ncyc, issued, popped, max_out, hold_bad, done_cyc;
    bit done_seen, valid_seen, prev_stall;
    logic [7:0] prev_d;
    logic prev_l;
    int rd_addr[$], rd_cyc[$], tx_data[$], tx_last[$], tx_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        ncyc = 0; issued = 0; popped = 0; max_out = 0; hold_bad = 0; done_cyc = -1;
        done_seen = 0; valid_seen = 0; prev_stall = 0;
        rd_addr.delete(); rd_cyc.delete(); tx_data.delete(); tx_last.delete(); tx_cyc.delete();
    endtask

    function automatic logic rdy_bp(input int c);
        if (c <= 10) return 1'b0;
        if (c == 11 || c == 13) return 1'b1;
        if (c == 12 || c == 14) return 1'b0;
        return 1'b1;
    endfunction

    // One clock cycle: apply TxReady, observe mid-cycle, log events, advance.
    task automatic cyc(input logic rdy);
        bus.TxReady = rdy;
        #1;
        if (bus.RdClockEn === 1'b1) begin
            rd_addr.push_back(int'(bus.RdAddress)); rd_cyc.push_back(ncyc); issued++;
        end
        if (issued - popped > max_out) max_out = issued - popped;
        if (bus.TxValid === 1'b1) valid_seen = 1;
        if (prev_stall && !(bus.TxValid === 1'b1 && bus.TxData === prev_d && bus.TxLast === prev_l))
            hold_bad++;
        prev_stall = (bus.TxValid === 1'b1) && !rdy;
        prev_d = bus.TxData;
        prev_l = bus.TxLast;
        if (bus.TxValid === 1'b1 && rdy) begin
            tx_data.push_back(int'(bus.TxData)); tx_last.push_back(int'(bus.TxLast));
            tx_cyc.push_back(ncyc); popped++;
        end
        if (bus.Done === 1'b1 && !done_seen) begin done_seen = 1; done_cyc = ncyc; end
        @(posedge clk); #1;
        bus.Start = 1'b0;
        bus.Abort = 1'b0;
        ncyc++;
    endtask

    task automatic start(input int addr, input int len);
        clr();
        bus.StartAddr = ADDR_W'(addr);
        bus.Length    = LEN_W'(len);
        bus.Start     = 1'b1;
    endtask

    task automatic run(input int mode, input int maxc, input string tag);
        for (int k = 0; k < maxc && !done_seen; k++) cyc(mode == 0 ? 1'b1 : rdy_bp(ncyc));
        check({tag, "_done_seen"}, 32'(done_seen), 1);
        check({tag, "_busy_after"}, 32'(bus.Busy), 0);
    endtask

    task automatic check_frame(input string tag, input int addr, input int len, input int dcyc);
        int bad = 0;
        check({tag, "_nreads"}, rd_addr.size(), len);
        check({tag, "_nbytes"}, tx_data.size(), len);
        for (int i = 0; i < len; i++) begin
            if (i < rd_addr.size() && rd_addr[i] != (addr + i) % MAX_LEN) bad++;
            if (i < tx_data.size() &&
                (tx_data[i] != int'(mem[(addr + i) % MAX_LEN]) || tx_last[i] != int'(i == len - 1))) bad++;
        end
        check({tag, "_order"}, bad, 0);
        if (dcyc >= 0) check({tag, "_done_cyc"}, done_cyc, dcyc);
    endtask

    initial begin
        for (int a = 0; a < MAX_LEN; a++) mem[a] = 8'(a) ^ 8'h5A;
        for (int i = 0; i < 4; i++) mem[16 + i] = 8'hA0 + 8'(i);
        bus.Start = 0; bus.StartAddr = '0; bus.Length = '0; bus.Abort = 0;
        bus.TxReady = 0; bus.Q = '0;
        clr();

        // Reset state
        #2;
        check("rst_busy", 32'(bus.Busy), 0);
        check("rst_done", 32'(bus.Done), 0);
        check("rst_rdaddr", 32'(bus.RdAddress), 0);
        check("rst_rden", 32'(bus.RdClockEn), 0);
        check("rst_txdata", 32'(bus.TxData), 0);
        check("rst_txvalid", 32'(bus.TxValid), 0);
        check("rst_txlast", 32'(bus.TxLast), 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // Basic 4-byte frame, no backpressure
        start(16, 4);
        run(0, 20, "f4");
        check_frame("f4", 16, 4, 7);
        check("f4_rd0_cyc", rd_cyc[0], 1);
        check("f4_rd3_cyc", rd_cyc[3], 4);
        check("f4_rd3_addr", rd_addr[3], 32'h013);
        check("f4_byte0", tx_data[0], 32'hA0);
        check("f4_byte3", tx_data[3], 32'hA3);
        check("f4_tx0_cyc", tx_cyc[0], 3);
        check("f4_tx3_cyc", tx_cyc[3], 6);

        // Address wrap, started the cycle after DONE
        start(32'h3FE, 4);
        run(0, 20, "wrap");
        check_frame("wrap", 32'h3FE, 4, 7);
        check("wrap_rd2_addr", rd_addr[2], 32'h000);

        // Backpressure
        start(32'h080, 16);
        run(1, 80, "bp");
        check_frame("bp", 32'h080, 16, -1);
        check("bp_max_outstanding", max_out, 4);
        check("bp_hold", hold_bad, 0);

        // Zero length
        start(32'h123, 0);
        run(0, 10, "len0");
        check("len0_done_cyc", done_cyc, 1);
        check("len0_nreads", rd_addr.size(), 0);
        check("len0_valid", 32'(valid_seen), 0);

        // Full 1024-byte frame
        start(32'h200, 1024);
        run(0, 1100, "len1024");
        check_frame("len1024", 32'h200, 1024, 1027);
        check("len1024_last_addr", rd_addr[1023], 32'h1FF);

        // Abort after 5 bytes; a Start while busy is ignored
        start(32'h100, 20);
        for (int k = 0; k < 20 && tx_data.size() < 5; k++) begin
            if (ncyc == 2) begin
                bus.StartAddr = ADDR_W'(32'h300); bus.Length = LEN_W'(2); bus.Start = 1'b1;
            end
            cyc(1'b1);
        end
        check("abort_pre_bytes", tx_data.size(), 5);
        begin
            int bad = 0;
            for (int i = 0; i < tx_data.size(); i++)
                if (tx_data[i] != int'(mem[32'h100 + i])) bad++;
            check("abort_pre_order", bad, 0);
        end
        bus.Abort = 1'b1;
        cyc(1'b0);
        #1;
        check("abort_txvalid", 32'(bus.TxValid), 0);
        check("abort_busy", 32'(bus.Busy), 0);
        check("abort_rden", 32'(bus.RdClockEn), 0);
        check("abort_no_done", 32'(done_seen), 0);
        clr();
        for (int k = 0; k < 5; k++) cyc(1'b1);
        check("abort_quiet_valid", 32'(valid_seen), 0);
        check("abort_quiet_done", 32'(done_seen), 0);
        start(32'h050, 3);
        run(0, 20, "restart");
        check_frame("restart", 32'h050, 3, 6);

        // Asynchronous reset mid-frame
        start(32'h000, 8);
        for (int k = 0; k < 5; k++) cyc(1'b1);
        #2;
        check("areset_pre_valid", 32'(bus.TxValid), 1);
        rst = 1'b1;
        #1;
        check("areset_busy", 32'(bus.Busy), 0);
        check("areset_done", 32'(bus.Done), 0);
        check("areset_rdaddr", 32'(bus.RdAddress), 0);
        check("areset_rden", 32'(bus.RdClockEn), 0);
        check("areset_txdata", 32'(bus.TxData), 0);
        check("areset_txvalid", 32'(bus.TxValid), 0);
        check("areset_txlast", 32'(bus.TxLast), 0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        start(32'h020, 2);
        run(0, 20, "post_rst");
        check_frame("post_rst", 32'h020, 2, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
